mov_src_encoder: RTL and testbench

MOV_SRC_ENCODER -- requirements
Module: mov_src_encoder

---
 rtl/mov_pkg.sv | 12 +
 rtl/mov_rr_pick.sv | 33 +++
 rtl/mov_src_encoder.sv | 87 ++++++++
 tb/tb_mov_src_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mov_pkg.sv
// rtl/mov_pkg.sv - shared defaults and FSM state type for the mov source encoder
package mov_pkg;

  localparam int N_SRC_DEFAULT = 16;
  localparam int IDX_W_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } mov_state_t;

endpackage

// File: rtl/mov_rr_pick.sv
// rtl/mov_rr_pick.sv - combinational round-robin pick: lowest pending index at or after ptr, wrapping
module mov_rr_pick
  import mov_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    // Scan from the farthest slot back toward ptr so the nearest hit is written last.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_SRC) begin
        j = j - N_SRC;
      end
      if (pending[j[IDX_W-1:0]]) begin
        idx   = j[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mov_src_encoder.sv
// rtl/mov_src_encoder.sv - captures mov requests and offers them one at a time, round-robin, to the control unit
module mov_src_encoder
  import mov_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_SRC-1:0] req_in,
  output logic [IDX_W-1:0] mov_src_bin,
  output logic             mov_src_valid,
  input  logic             mov_src_ready,
  output logic [N_SRC-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  mov_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             grant;
  logic [N_SRC-1:0] req_eff;
  logic [N_SRC-1:0] clr_mask;

  assign req_eff = enable ? req_in : '0;
  assign grant   = (state == OFFER) && mov_src_valid && mov_src_ready;
  assign busy    = (|pending) | mov_src_valid;

  always_comb begin
    clr_mask = '0;
    if (grant) begin
      clr_mask[mov_src_bin] = 1'b1;
    end
  end

  mov_rr_pick #(
    .N_SRC(N_SRC),
    .IDX_W(IDX_W)
  ) u_pick (
    .pending(pending),
    .ptr    (ptr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      pending       <= '0;
      mov_src_bin   <= '0;
      mov_src_valid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // A new request is OR'd in after the grant clear, so set wins over clear.
      pending <= (pending & ~clr_mask) | req_eff;
      if (|(req_eff & pending & ~clr_mask)) begin
        overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (enable && pick_found) begin
            mov_src_bin   <= pick_idx;
            mov_src_valid <= 1'b1;
            state         <= OFFER;
          end
        end
        OFFER: begin
          if (mov_src_ready) begin
            mov_src_valid <= 1'b0;
            state         <= IDLE;
            if (mov_src_bin == IDX_W'(N_SRC - 1)) begin
              ptr <= '0;
            end else begin
              ptr <= mov_src_bin + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mov_src_encoder.sv
// tb/tb_mov_src_encoder.sv - directed and randomized checks of mov_src_encoder against a reference model
module tb_mov_src_encoder;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [N-1:0]  req_in;
  logic [3:0]    mov_src_bin;
  logic          mov_src_valid;
  logic          mov_src_ready;
  logic [N-1:0]  pending;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  mov_src_encoder #(.N_SRC(16), .IDX_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req_in       (req_in),
    .mov_src_bin  (mov_src_bin),
    .mov_src_valid(mov_src_valid),
    .mov_src_ready(mov_src_ready),
    .pending      (pending),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; req_in = '0; mov_src_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int rr_search(logic [N-1:0] p, int from);
    for (int k = 0; k < N; k++) begin
      if (p[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; req_in = 16'hFFFF; mov_src_ready = 1'b0;
    tick();
    checks++; if (mov_src_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mov_src_valid); end
    checks++; if (mov_src_bin !== 4'd0) begin errors++; $display("FAIL reset_bin: got %0d expected 0", mov_src_bin); end
    checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0000", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; req_in = '0; enable = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    enable = 1'b1; mov_src_ready = 1'b1; req_in = 16'h0001;
    tick();
    req_in = '0;
    checks++; if (pending !== 16'h0001) begin errors++; $display("FAIL single_pending: got %h expected 0001", pending); end
    checks++; if (mov_src_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", mov_src_valid); end
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd0) begin errors++; $display("FAIL single_offer: got valid=%b bin=%0d expected valid=1 bin=0", mov_src_valid, mov_src_bin); end
    tick();
    checks++; if (mov_src_valid !== 1'b0 || pending !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL single_after: got valid=%b pending=%h busy=%b expected 0/0000/0", mov_src_valid, pending, busy); end
    req_in = 16'h0005;
    tick();
    req_in = '0;
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd2) begin errors++; $display("FAIL single_ptr1: got valid=%b bin=%0d expected valid=1 bin=2", mov_src_valid, mov_src_bin); end
    tick();
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd0) begin errors++; $display("FAIL single_wrap: got valid=%b bin=%0d expected valid=1 bin=0", mov_src_valid, mov_src_bin); end
  endtask

  task automatic test_multi();
    int got[$];
    int exp_ord[3] = '{0, 8, 15};
    do_reset();
    enable = 1'b1; mov_src_ready = 1'b1; req_in = 16'h8101;
    tick();
    req_in = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mov_src_valid === 1'b1) got.push_back(int'(mov_src_bin));
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL multi_count: got %0d grants expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL multi_order[%0d]: got none expected %0d", i, exp_ord[i]); end
      else if (got[i] != exp_ord[i]) begin errors++; $display("FAIL multi_order[%0d]: got %0d expected %0d", i, got[i], exp_ord[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy: got %b expected 0", busy); end
    req_in = 16'h4002;
    tick();
    req_in = '0;
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd1) begin errors++; $display("FAIL multi_ptr0: got valid=%b bin=%0d expected valid=1 bin=1", mov_src_valid, mov_src_bin); end
  endtask

  task automatic test_hold();
    do_reset();
    enable = 1'b1; mov_src_ready = 1'b0; req_in = 16'h0008;
    tick();
    req_in = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      enable = i[0]; req_in = 16'h0010;
      tick();
      checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd3) begin errors++; $display("FAIL hold[%0d]: got valid=%b bin=%0d expected valid=1 bin=3", i, mov_src_valid, mov_src_bin); end
    end
    req_in = '0; enable = 1'b1; mov_src_ready = 1'b1;
    tick();
    checks++; if (mov_src_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got valid=%b expected 0", mov_src_valid); end
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd4) begin errors++; $display("FAIL hold_next: got valid=%b bin=%0d expected valid=1 bin=4", mov_src_valid, mov_src_bin); end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; mov_src_ready = 1'b0; req_in = 16'h0024;
    tick();
    req_in = '0;
    tick();
    checks++; if (mov_src_bin !== 4'd2 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got bin=%0d ovf=%b expected bin=2 ovf=0", mov_src_bin, overflow); end
    req_in = 16'h0020;
    tick();
    req_in = '0;
    checks++; if (overflow !== 1'b1 || pending !== 16'h0024) begin errors++; $display("FAIL ovf_set: got ovf=%b pending=%h expected ovf=1 pending=0024", overflow, pending); end
    mov_src_ready = 1'b1;
    tick();
    checks++; if (pending !== 16'h0020 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got pending=%h ovf=%b expected 0020/1", pending, overflow); end
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd5) begin errors++; $display("FAIL ovf_offer5: got valid=%b bin=%0d expected valid=1 bin=5", mov_src_valid, mov_src_bin); end
    do_reset();
    enable = 1'b1; mov_src_ready = 1'b1; req_in = 16'h0020;
    tick();
    req_in = '0;
    tick();
    req_in = 16'h0020;
    tick();
    req_in = '0;
    checks++; if (pending !== 16'h0020 || overflow !== 1'b0 || mov_src_valid !== 1'b0) begin errors++; $display("FAIL set_wins: got pending=%h ovf=%b valid=%b expected 0020/0/0", pending, overflow, mov_src_valid); end
    tick();
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd5) begin errors++; $display("FAIL set_wins_reoffer: got valid=%b bin=%0d expected valid=1 bin=5", mov_src_valid, mov_src_bin); end
  endtask

  task automatic test_disabled();
    do_reset();
    enable = 1'b0; mov_src_ready = 1'b1; req_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pending !== 16'h0 || mov_src_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL disabled[%0d]: got pending=%h valid=%b busy=%b expected 0000/0/0", i, pending, mov_src_valid, busy); end
    end
    req_in = '0; enable = 1'b1;
    tick();
    tick();
    checks++; if (mov_src_valid !== 1'b0 || pending !== 16'h0) begin errors++; $display("FAIL disabled_after: got valid=%b pending=%h expected 0/0000", mov_src_valid, pending); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    enable = 1'b1; mov_src_ready = 1'b0; req_in = 16'h0080;
    tick();
    tick();
    req_in = '0;
    checks++; if (mov_src_valid !== 1'b1 || mov_src_bin !== 4'd7 || overflow !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid=%b bin=%0d ovf=%b expected 1/7/1", mov_src_valid, mov_src_bin, overflow); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mov_src_valid !== 1'b0 || pending !== 16'h0 || overflow !== 1'b0 || mov_src_bin !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got valid=%b pending=%h ovf=%b bin=%0d busy=%b expected all 0", mov_src_valid, pending, overflow, mov_src_bin, busy);
    end
    tick();
    rst = 1'b0; mov_src_ready = 1'b1;
    tick();
    tick();
    checks++; if (mov_src_valid !== 1'b0 || pending !== 16'h0) begin errors++; $display("FAIL rstmid_after: got valid=%b pending=%h expected 0/0000", mov_src_valid, pending); end
  endtask

  task automatic test_random();
    logic [N-1:0] mp, set_m, clr_m, np;
    int  mptr, mbin;
    bit  mv, movf;
    do_reset();
    mp = '0; mptr = 0; mbin = 0; mv = 1'b0; movf = 1'b0;
    for (int c = 0; c < 500; c++) begin
      enable = ($urandom_range(0, 3) != 0);
      req_in = '0;
      if ($urandom_range(0, 2) == 0) req_in = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req_in = req_in | 16'($urandom);
      mov_src_ready = ($urandom_range(0, 2) != 0);
      set_m = enable ? req_in : '0;
      clr_m = (mv && mov_src_ready) ? 16'(1 << mbin) : '0;
      if ((set_m & mp & ~clr_m) != '0) movf = 1'b1;
      np = (mp & ~clr_m) | set_m;
      if (mv) begin
        if (mov_src_ready) begin mv = 1'b0; mptr = (mbin + 1) % N; end
      end else if (enable && mp != '0) begin
        mbin = rr_search(mp, mptr); mv = 1'b1;
      end
      mp = np;
      tick();
      checks++; if (mov_src_valid !== mv) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, mov_src_valid, mv); end
      if (mv) begin
        checks++; if (mov_src_bin !== 4'(mbin)) begin errors++; $display("FAIL rnd_bin@%0d: got %0d expected %0d", c, mov_src_bin, mbin); end
      end
      checks++; if (pending !== mp) begin errors++; $display("FAIL rnd_pending@%0d: got %h expected %h", c, pending, mp); end
      checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b expected %b", c, overflow, movf); end
      checks++; if (busy !== ((mp != '0) || mv)) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", c, busy, ((mp != '0) || mv)); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_in = '0; mov_src_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_overflow();
    test_disabled();
    test_reset_mid_offer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
